i2s_tx_serializer: RTL

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: left/right holding registers, a slot-edge-driven shift FSM and MSB-first
// output. Define I2S_TX_UNDERRUN_EN to enable the underrun pulse and its saturating counter.
module i2s_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  lrck,
  input  logic [DATA_WIDTH-1:0] ldata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  l_vld,
  input  logic                  r_vld,
  output logic                  dacdat,
  output logic                  l_req,
  output logic                  r_req,
  output logic                  busy,
  output logic                  underrun,
  output logic [7:0]            underrun_cnt
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StWaitSync, StShift, StPad} state_t;

  state_t                state;
  logic                  lrck_d;
  logic [DATA_WIDTH-1:0] l_hold, r_hold, sreg;
  logic                  l_fresh, r_fresh;
  logic [CntW-1:0]       bit_cnt;

  logic                  slot_edge;
  logic [DATA_WIDTH-1:0] sel_hold;
  logic                  sel_fresh, sel_vld;

  // The new lrck value selects the channel being loaded: 0 left, 1 right.
  always_comb begin
    slot_edge = (lrck != lrck_d);
    sel_hold  = lrck ? r_hold  : l_hold;
    sel_fresh = lrck ? r_fresh : l_fresh;
    sel_vld   = lrck ? r_vld   : l_vld;
  end

  // A write wins over the clear on a same-channel load, so the new sample stays fresh.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      lrck_d  <= 1'b0;
      l_hold  <= '0;
      r_hold  <= '0;
      l_fresh <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      lrck_d <= lrck;
      if (l_vld) l_hold <= ldata;
      if (r_vld) r_hold <= rdata;
      if (l_vld)                  l_fresh <= 1'b1;
      else if (slot_edge && !lrck) l_fresh <= 1'b0;
      if (r_vld)                  r_fresh <= 1'b1;
      else if (slot_edge && lrck)  r_fresh <= 1'b0;
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state   <= StWaitSync;
      sreg    <= '0;
      bit_cnt <= '0;
      dacdat  <= 1'b0;
      busy    <= 1'b0;
      l_req   <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      l_req <= 1'b0;
      r_req <= 1'b0;
      if (slot_edge) begin
        // MSB goes out on this edge; the remaining bits sit left-aligned in sreg.
        sreg    <= {sel_hold[DATA_WIDTH-2:0], 1'b0};
        dacdat  <= sel_hold[DATA_WIDTH-1];
        bit_cnt <= CntW'(1);
        state   <= StShift;
        busy    <= 1'b1;
        l_req   <= ~lrck;
        r_req   <= lrck;
      end else begin
        case (state)
          StShift: begin
            if (bit_cnt == CntW'(DATA_WIDTH)) begin
              state  <= StPad;
              busy   <= 1'b0;
              dacdat <= 1'b0;
            end else begin
              dacdat  <= sreg[DATA_WIDTH-1];
              sreg    <= {sreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
          StPad: begin
            dacdat <= 1'b0;
            busy   <= 1'b0;
          end
          default: begin
            dacdat <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_EN
  logic underrun_now;
  assign underrun_now = slot_edge && !sel_fresh && !sel_vld;

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      underrun <= underrun_now;
      if (underrun_now && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`else
  logic unused_fresh;
  assign unused_fresh = sel_fresh ^ sel_vld;
  assign underrun     = 1'b0;
  assign underrun_cnt = 8'd0;
`endif

endmodule
